// File: rtl/bpsk_frame_unpacker.sv
// bpsk_frame_unpacker
//   Takes 128-bit demapped blocks from the BPSK demapper and holds them in a
//   small circular buffer. It looks for a frame header (sync word plus a
//   length byte) and streams the frame payload as bytes, MSB-first.
//
//   Ports:
//     CLK           clock
//     RST           synchronous reset, active-low
//     valid_i       one-cycle pulse; din holds a complete block
//     din[127:0]    demapped block, bit 127 = first received bit
//     dout[7:0]     payload byte (0 when valid_o is low)
//     valid_o       dout valid
//     ready_i       downstream accepts dout
//     frame_start   high with the first payload byte of a frame
//     frame_end     high with the last payload byte of a frame
//     overflow      sticky: a block was dropped because the buffer was full
//     sync_err_cnt  saturating count of discarded non-header blocks
//     busy          frame in progress or buffer non-empty
//
//   Output handshake: a byte transfers on every CLK edge where
//   valid_o && ready_i. valid_o, dout, frame_start and frame_end come only
//   from registers, never from ready_i. Once valid_o is raised, dout holds
//   until the byte is accepted or RST is asserted.
module bpsk_frame_unpacker #(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int          BUF_DEPTH = 2,
    parameter int          CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_i,
    input  logic [127:0]     din,
    output logic [7:0]       dout,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_start,
    output logic             frame_end,
    output logic             overflow,
    output logic [CNT_W-1:0] sync_err_cnt,
    output logic             busy
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(BUF_DEPTH);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t           state;
    logic [127:0]     mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;
    logic [3:0]       idx;
    logic [7:0]       remaining;
    logic             first;

    logic             empty;
    logic             full;
    logic [127:0]     head;
    logic [127:0]     head_shifted;
    logic             hdr_valid;
    logic             accept;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty     = (fill == '0);
    assign full      = (fill == FULL_LVL);
    assign head      = mem[rd_ptr];
    assign hdr_valid = (head[127:112] == SYNC_WORD) && (head[111:104] != 8'd0);

    // Byte idx of the head block is moved to the top so it can be sliced off.
    assign head_shifted = head << {idx, 3'b000};

    assign valid_o     = (state == PAYLOAD) && !empty;
    assign dout        = valid_o ? head_shifted[127:120] : 8'h00;
    assign frame_start = valid_o && first;
    assign frame_end   = valid_o && (remaining == 8'd1);
    assign busy        = (state != HUNT) || !empty;

    assign accept = valid_o && ready_i;

    // The head block leaves the buffer when it is rejected in HUNT, or once
    // its last useful byte is accepted (end of frame or end of block).
    assign pop = ((state == HUNT) && !empty && !hdr_valid) ||
                 (accept && ((remaining == 8'd1) || (idx == 4'd15)));

    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign push = valid_i && (!full || pop);
    assign drop = valid_i && full && !pop;

    // Block storage needs no reset: fill alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= HUNT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            idx          <= 4'd0;
            remaining    <= 8'd0;
            first        <= 1'b0;
            overflow     <= 1'b0;
            sync_err_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + (PTR_W + 1)'(1);
                2'b01:   fill <= fill - (PTR_W + 1)'(1);
                default: fill <= fill;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                HUNT: begin
                    if (!empty) begin
                        if (hdr_valid) begin
                            // Header stays at the head; payload starts at byte 3.
                            state     <= PAYLOAD;
                            idx       <= 4'd3;
                            remaining <= head[111:104];
                            first     <= 1'b1;
                        end else if (sync_err_cnt != '1) begin
                            sync_err_cnt <= sync_err_cnt + CNT_W'(1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        remaining <= remaining - 8'd1;
                        first     <= 1'b0;
                        if (remaining == 8'd1) begin
                            state <= HUNT;
                            idx   <= 4'd0;
                        end else begin
                            // Wraps from 15 to 0 as the frame moves to the next block.
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
